// File: rtl/shift_seq.sv
// shift_seq: multi-cycle sequencer for register-specified ARM shifts.
// Rm is shifted one bit per clock, so the result is ready k edges after accept.
// The result and carry-out are ARM-exact for LSL, LSR, ASR and ROR.
module shift_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic             flush,
  input  logic [WIDTH-1:0] rm_val,
  input  logic [1:0]       shift_type,
  input  logic [7:0]       shift_amt,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work;
  logic [1:0]       typ;
  logic             sign;
  logic             cy;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] k_in;
  logic [WIDTH:0]   step;
  logic             accept;

  // Number of 1-bit iterations needed.
  // A count of 33 flushes LSL/LSR to zero with carry 0.
  // ASR saturates at 32, because further shifts do not change the result.
  // ROR only uses the low 5 bits of the amount.
  function automatic logic [CNT_W-1:0] iter_count(input logic [1:0] t, input logic [7:0] n);
    logic [CNT_W-1:0] k;
    k = '0;
    case (t)
      T_LSL, T_LSR: k = (n > 8'd33) ? CNT_W'(33) : CNT_W'(n);
      T_ASR:        k = (n > 8'd32) ? CNT_W'(32) : CNT_W'(n);
      default:      k = CNT_W'(n[4:0]);
    endcase
    return k;
  endfunction

  // One shift step. The return value is {carry, word}.
  // ASR fills with the sign bit latched at accept, not the current MSB.
  function automatic logic [WIDTH:0] shift_step(input logic [1:0] t, input logic [WIDTH-1:0] w,
                                                input logic s);
    logic [WIDTH:0] r;
    case (t)
      T_LSL:   r = {w[WIDTH-1], w[WIDTH-2:0], 1'b0};
      T_LSR:   r = {w[0], 1'b0, w[WIDTH-1:1]};
      T_ASR:   r = {w[0], s, w[WIDTH-1:1]};
      default: r = {w[0], w[0], w[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  assign ready  = (state == IDLE) || (state == DONE);
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);
  assign accept = start && ready && !flush;
  assign k_in   = iter_count(shift_type, shift_amt);
  assign step   = shift_step(typ, work, sign);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // flush wins over both iteration and a new request.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = (k_in == '0) ? DONE : SHIFT;
        else        state_nxt = IDLE;
      end
      SHIFT: begin
        if (flush)                  state_nxt = IDLE;
        else if (cnt == CNT_W'(1))  state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working register, counter and published result.
  // The result changes only on a zero-count accept or on the final shift edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= '0;
      typ       <= '0;
      sign      <= 1'b0;
      cy        <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      work <= rm_val;
      typ  <= shift_type;
      sign <= rm_val[WIDTH-1];
      cy   <= carry_in;
      cnt  <= k_in;
      if (k_in == '0) begin
        result    <= rm_val;
        carry_out <= (shift_amt == 8'd0) ? carry_in : rm_val[WIDTH-1];
      end
    end else if (state == SHIFT && !flush) begin
      {cy, work} <= step;
      cnt        <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        result    <= step[WIDTH-1:0];
        carry_out <= step[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq.
// The stimulus pushes the expected result, carry, done cycle and busy length.
// A negedge monitor pops an entry each time done is seen and compares it.
module tb_shift_seq;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             flush = 1'b0;
  logic             carry_in = 1'b0;
  logic [WIDTH-1:0] rm_val = '0;
  logic [1:0]       shift_type = '0;
  logic [7:0]       shift_amt = '0;
  logic             ready, busy, done, carry_out;
  logic [WIDTH-1:0] result;

  typedef struct {
    logic [31:0] res;
    logic        c;
    int          cyc;
    int          k;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;
  int   busy_run = 0;
  int   ea, eb, ec, ed;

  shift_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .flush(flush),
    .rm_val(rm_val), .shift_type(shift_type), .shift_amt(shift_amt),
    .carry_in(carry_in), .busy(busy), .done(done), .result(result),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every done pulse against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done) begin
          if (sbq.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_done: got result %h carry %b with nothing outstanding",
                     result, carry_out);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk({e.name, "_result"}, result, e.res);
            chk({e.name, "_carry"}, {31'd0, carry_out}, {31'd0, e.c});
            chk({e.name, "_done_cycle"}, cyc, e.cyc);
            chk({e.name, "_busy_cycles"}, busy_run, e.k);
          end
          busy_run = 0;
        end else if (busy) begin
          busy_run++;
        end else begin
          busy_run = 0;
        end
      end
    end
  end

  // Hold start until the request is accepted, then record the expected response.
  task automatic issue(input logic [1:0] t, input logic [7:0] n, input logic [31:0] rm,
                       input logic cin, input bit expect_done, input logic [31:0] er,
                       input logic ecy, input int k, input string name, output int e0);
    int waited;
    bit acc;
    waited = 0;
    acc    = 1'b0;
    e0     = -1;
    while (!acc && waited < 200) begin
      @(negedge clk);
      shift_type = t;
      shift_amt  = n;
      rm_val     = rm;
      carry_in   = cin;
      start      = 1'b1;
      acc        = ready && !flush;
      @(posedge clk);
      #1;
      waited++;
    end
    start = 1'b0;
    if (!acc) begin
      checks++;
      errs++;
      $display("FAIL %s_accept: got no accept expected accept within 200 cycles", name);
    end else begin
      e0 = cyc;
      if (expect_done) sbq.push_back('{er, ecy, cyc + k, k, name});
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sbq.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errs++;
      $display("FAIL drain: got %0d outstanding expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_carry", {31'd0, carry_out}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'b00, 8'd4, 32'h0000_00F1, 1'b0, 1, 32'h0000_0F10, 1'b0, 4, "lsl4", ea);
    drain();
    issue(2'b01, 8'd32, 32'h8000_0001, 1'b0, 1, 32'h0, 1'b1, 32, "lsr32", ea);
    drain();
    issue(2'b01, 8'd40, 32'h8000_0001, 1'b1, 1, 32'h0, 1'b0, 33, "lsr40", ea);
    drain();
    issue(2'b10, 8'd200, 32'h8000_0000, 1'b0, 1, 32'hFFFF_FFFF, 1'b1, 32, "asr200", ea);
    drain();
    issue(2'b11, 8'd1, 32'h0000_0003, 1'b0, 1, 32'h8000_0001, 1'b1, 1, "ror1", ea);
    drain();
    issue(2'b00, 8'd0, 32'h1234_5678, 1'b1, 1, 32'h1234_5678, 1'b1, 0, "amt0", ea);
    drain();
    issue(2'b11, 8'd64, 32'h8000_0000, 1'b0, 1, 32'h8000_0000, 1'b1, 0, "ror64", ea);
    drain();
    issue(2'b00, 8'd32, 32'h0000_0001, 1'b0, 1, 32'h0, 1'b1, 32, "lsl32", ea);
    drain();

    // Back-to-back: each request is held through busy, then accepted from DONE.
    issue(2'b01, 8'd5, 32'h0000_00F0, 1'b0, 1, 32'h0000_0007, 1'b1, 5, "b2b_lsr5", ea);
    issue(2'b10, 8'd4, 32'h8000_0010, 1'b0, 1, 32'hF800_0001, 1'b0, 4, "b2b_asr4", eb);
    issue(2'b11, 8'd8, 32'h1234_5678, 1'b0, 1, 32'h7812_3456, 1'b0, 8, "b2b_ror8", ec);
    issue(2'b11, 8'd36, 32'h1234_5678, 1'b0, 1, 32'h8123_4567, 1'b1, 4, "b2b_ror36", ed);
    chk("b2b_gap1", eb, ea + 5 + 1);
    chk("b2b_gap2", ec, eb + 4 + 1);
    chk("b2b_gap3", ed, ec + 8 + 1);
    drain();

    // Flush at edge 3 of an LSL by 10: no done, previous outputs kept.
    issue(2'b00, 8'd10, 32'h0000_FFFF, 1'b0, 0, 32'h0, 1'b0, 10, "flush_lsl", ea);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_ready", {31'd0, ready}, 32'd1);
    repeat (12) @(negedge clk);
    chk("flush_result_kept", result, 32'h8123_4567);
    chk("flush_carry_kept", {31'd0, carry_out}, 32'd1);

    // A request presented together with flush is not accepted.
    @(negedge clk);
    shift_type = 2'b00;
    shift_amt  = 8'd3;
    rm_val     = 32'h1;
    start      = 1'b1;
    flush      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_prio_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    chk("flush_prio_result", result, 32'h8123_4567);

    // Asynchronous reset in the middle of a shift.
    issue(2'b10, 8'd200, 32'h8000_0000, 1'b0, 0, 32'h0, 1'b0, 32, "rst_mid", ea);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_result", result, 32'h0);
    chk("arst_carry", {31'd0, carry_out}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b00, 8'd1, 32'h8000_0001, 1'b0, 1, 32'h0000_0002, 1'b1, 1, "post_rst_lsl1", ea);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
